// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one host command at a time, drives operands and
// select bits to an external 8-bit combinational ALU, waits SETTLE cycles,
// captures the ALU result and presents it as a response. Opcode 111 is
// answered immediately with an error response and never reaches the ALU.
module alu_op_sequencer #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic [7:0]  alu_x,
  output logic [7:0]  alu_y,
  output logic        alu_s2,
  output logic        alu_s1,
  output logic        alu_s0,
  input  logic [7:0]  alu_z,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [2:0]  rsp_op,
  output logic        rsp_err,
  output logic [15:0] cmd_count
);

  // The settle counter is 4 bits wide, so only 1..15 can be represented.
  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("alu_op_sequencer: SETTLE must be in the range 1..15");
  end

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] settle_cnt;

  // Ready is a decode of the state register, gated by reset so a command can
  // be taken on the very first edge after reset is released.
  assign cmd_ready = (state == S_IDLE) && !rst;

  // Sequencer FSM: command acceptance, ALU settle wait, response handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= 4'd0;
      alu_x      <= 8'h00;
      alu_y      <= 8'h00;
      alu_s2     <= 1'b0;
      alu_s1     <= 1'b0;
      alu_s0     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_op     <= 3'b000;
      rsp_err    <= 1'b0;
      cmd_count  <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            rsp_op <= cmd_op;
            if (cmd_op == OP_ILLEGAL) begin
              // ALU operands are left untouched; answer straight away.
              rsp_data  <= 8'h00;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              alu_x                    <= cmd_a;
              alu_y                    <= cmd_b;
              {alu_s2, alu_s1, alu_s0} <= cmd_op;
              settle_cnt               <= SETTLE_CNT;
              state                    <= S_SETTLE;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) begin
            // Result is passed through as-is, compare codes included.
            rsp_data  <= alu_z;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            state <= S_SETTLE;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_count <= cmd_count + 16'd1;
            state     <= S_IDLE;
          end else begin
            state <= S_RESP;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: SETTLE, default 1, number of cycles between driving ALU operands and capturing alu_z; legal range 1..15, other values SHALL fail elaboration.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  host command present.
REQ-005 cmd_ready  output  1  sequencer accepts command.
REQ-006 cmd_op  input  3  opcode: 000 AND, 001 OR, 010 shift-right, 011 shift-left, 100 add, 101 sub, 110 compare, 111 illegal.
REQ-007 cmd_a, cmd_b  input  8 each  operands.
REQ-008 alu_x, alu_y  output  8 each  operands driven to the 8-bit ALU.
REQ-009 alu_s2, alu_s1, alu_s0  output  1 each  ALU select bits, {alu_s2,alu_s1,alu_s0} = opcode.
REQ-010 alu_z  input  8  ALU result.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  host accepts response.
REQ-013 rsp_data  output  8  captured result.
REQ-014 rsp_op  output  3  opcode of the response.
REQ-015 rsp_err  output  1  response is for illegal opcode 111.
REQ-016 cmd_count  output  16  completed response handshakes.

Function
REQ-017 FSM states SHALL be IDLE, SETTLE, RESP.
REQ-018 cmd_ready SHALL be 1 only in IDLE; command accepted on edge where cmd_valid & cmd_ready.
REQ-019 On acceptance of legal op: alu_x<=cmd_a, alu_y<=cmd_b, select bits<=cmd_op, rsp_op<=cmd_op, settle counter<=SETTLE, state->SETTLE.
REQ-020 In SETTLE, counter SHALL decrement each edge; on the edge where counter==1, rsp_data<=alu_z, rsp_err<=0, rsp_valid<=1, state->RESP.
REQ-021 Latency: command accepted on edge N -> rsp_valid high after edge N+SETTLE.
REQ-022 On acceptance of op 111: ALU outputs unchanged, rsp_op<=111, rsp_data<=0, rsp_err<=1, rsp_valid<=1, state->RESP directly (rsp_valid high after edge N).
REQ-023 alu_x, alu_y, select bits SHALL hold stable from acceptance until next acceptance, including through RESP and IDLE.
REQ-024 In RESP, rsp_valid, rsp_data, rsp_op, rsp_err SHALL hold stable until rsp_ready sampled 1; on that edge rsp_valid<=0, cmd_count<=cmd_count+1, state->IDLE.
REQ-025 rsp_ready already 1 on RESP entry SHALL complete handshake on first RESP cycle.
REQ-026 cmd_count SHALL wrap 0xFFFF -> 0x0000; counts illegal-op responses too.
REQ-027 Compare results SHALL pass unmodified (01 x>y, 02 x<y, 00 equal); no decoding of alu_z.
REQ-028 cmd_valid while not in IDLE SHALL be ignored; command inputs may change freely then.
REQ-029 Peak throughput: one legal op per SETTLE+2 cycles with rsp_ready held 1.

Reset
REQ-030 rst asserted SHALL immediately force state IDLE and all outputs to 0 except cmd_ready, which SHALL be 1 after rst deasserts; cmd_ready SHALL be 0 while rst is high.
REQ-031 rst mid-SETTLE or mid-RESP SHALL discard the pending operation without a response handshake or cmd_count change beyond reset to 0.
REQ-032 First command SHALL be acceptable on the first rising edge after rst deasserts.

Verification
REQ-033 SETTLE=1, op 100, a=0x3C, b=0x05, ALU model -> alu_x=0x3C, alu_y=0x05, selects 100; rsp_data=0x41 one cycle after accept; cmd_count=1 after handshake.
REQ-034 op 110, a=0x10, b=0x20 -> rsp_data=0x02; a=b=0x7F -> rsp_data=0x00.
REQ-035 op 111, a=0xFF -> rsp_valid next cycle, rsp_err=1, rsp_data=0x00, ALU outputs unchanged from previous op.
REQ-036 SETTLE=3, op 101, a=0x05, b=0x06, rsp_ready held 0 for 4 cycles -> rsp_data=0xFF stable, cmd_ready=0 throughout, extra cmd_valid ignored.
REQ-037 rst pulse during SETTLE -> no rsp_valid, all outputs 0, cmd_count=0, next command completes normally.
REQ-038 Preload via 65535 handshakes then one more -> cmd_count 0xFFFF -> 0x0000.
